// File: rtl/aes_inv_round_ctrl_if.sv
// Block/key handshake bundle for the iterative AES-128 inverse round sequencer.
// slave = sequencer side, master = FIFO / key store / sink side.
interface aes_inv_round_ctrl_if;
  localparam int unsigned BW = 128;
  localparam int unsigned KW = 4;

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [KW-1:0] rk_idx;
  logic [BW-1:0] rk_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          busy;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption round sequencer: one inverse round per clock.
// Optional feature macro: AES_INV_ROUND_ABORT_EN adds an 'abort' input that
// returns the sequencer to IDLE from ROUND or DONE, clearing the datapath.
module aes_inv_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input logic                  clk,
  input logic                  reset,
  aes_inv_round_ctrl_if.slave  bus
`ifdef AES_INV_ROUND_ABORT_EN
  ,
  input logic                  abort
`endif
);
  localparam int unsigned BW = 128;
  localparam int unsigned RW = 4;

  // Only the AES-128 round count is supported.
  generate
    if (NR != 10) begin : g_nr_chk
      $error("aes_inv_round_ctrl: only NR=10 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t          fsm;
  logic [RW-1:0] round;
  logic [BW-1:0] state;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          abort_c;
  logic [BW-1:0] t_c;
  logic [BW-1:0] mix_c;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse affine map followed by the GF(2^8) inverse (b^254, 0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] r;
    b  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq = b;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // InvShiftRows then InvSubBytes; byte r+4c sits at bits [127-8(r+4c) -: 8].
  function automatic logic [BW-1:0] inv_shift_sub(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [BW-1:0] inv_mix(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    logic [7:0]    a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d) ^ gmul(a0, 8'h09);
      o[111-32*c -: 8] = gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b) ^ gmul(a0, 8'h0d) ^ gmul(a1, 8'h09);
      o[103-32*c -: 8] = gmul(a3, 8'h0e) ^ gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09);
    end
    return o;
  endfunction

`ifdef AES_INV_ROUND_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // One inverse round of datapath; the final round skips InvMixColumns.
  always_comb begin
    t_c   = inv_shift_sub(state) ^ bus.rk_data;
    mix_c = inv_mix(t_c);
  end

  // Round-key index is a direct decode of the sequencer state.
  always_comb begin
    bus.rk_idx = '0;
    case (fsm)
      IDLE:    bus.rk_idx = RW'(NR);
      ROUND:   bus.rk_idx = round;
      default: bus.rk_idx = '0;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = state;

  // Sequencer: accept, NR rounds, hold result until the sink takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm         <= IDLE;
      round       <= '0;
      state       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= bus.in_data ^ bus.rk_data;
            round      <= RW'(NR - 1);
            fsm        <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          if (abort_c) begin
            state      <= '0;
            round      <= '0;
            fsm        <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (round != '0) begin
            state <= mix_c;
            round <= round - RW'(1);
          end else begin
            state       <= t_c;
            fsm         <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (abort_c || bus.out_ready) begin
            if (abort_c) begin
              state <= '0;
              round <= '0;
            end
            fsm         <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: known-answer vector plus random blocks/keys
// checked against a table-driven AES-128 decryption model.
module tb_aes_inv_round_ctrl;
  logic clk;
  logic reset;
`ifdef AES_INV_ROUND_ABORT_EN
  logic abort;
`endif

  aes_inv_round_ctrl_if bus ();

  aes_inv_round_ctrl #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef AES_INV_ROUND_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int           nvec;
  int           nerr;
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_tab [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key store: combinational lookup by requested index.
  assign bus.rk_data = rk_tab[bus.rk_idx];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product then polynomial reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] bsel(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook AES-128 inverse cipher on a 4x4 byte matrix m[row][col].
  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0]   m [4][4];
    logic [7:0]   n [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = bsel(ct, 4*c + r) ^ bsel(rk_tab[10], 4*c + r);
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          n[r][c] = isbox[m[r][(c - r + 4) % 4]] ^ bsel(rk_tab[rd], 4*c + r);
      if (rd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            m[r][c] = gm(n[r][c], 8'h0e) ^ gm(n[(r+1)%4][c], 8'h0b)
                    ^ gm(n[(r+2)%4][c], 8'h0d) ^ gm(n[(r+3)%4][c], 8'h09);
      end else begin
        m = n;
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = m[r][c];
    return o;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(bus.in_ready), 128'(1));
  endtask

  // One block: accept, scramble in_data during rounds, optional output stall.
  task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input int stall);
    wait_idle("idle_ready");
    chk("idle_rk_idx", 128'(bus.rk_idx), 128'(10));
    chk("idle_busy", 128'(bus.busy), 128'(0));
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int r = 9; r >= 0; r--) begin
      chk("round_rk_idx", 128'(bus.rk_idx), 128'(r));
      chk("round_in_ready", 128'(bus.in_ready), 128'(0));
      chk("round_out_valid", 128'(bus.out_valid), 128'(0));
      chk("round_busy", 128'(bus.busy), 128'(1));
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    for (int s = 0; s < stall; s++) begin
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_out_data", bus.out_data, pt);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("done_out_valid", 128'(bus.out_valid), 128'(1));
    chk("done_out_data", bus.out_data, pt);
    chk("done_busy", 128'(bus.busy), 128'(1));
    @(negedge clk);
    chk("post_out_valid", 128'(bus.out_valid), 128'(0));
    chk("post_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  // in_valid held high across two blocks; accepts must be NR+2 apart.
  task automatic b2b(input logic [127:0] c0, input logic [127:0] c1);
    logic [127:0] p [2];
    int t [2];
    int acc;
    int outs;
    p[0] = ref_dec(c0);
    p[1] = ref_dec(c1);
    t[0] = 0;
    t[1] = 0;
    acc  = 0;
    outs = 0;
    wait_idle("b2b_idle");
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && outs < 2; c++) begin
      bus.in_data  = (acc == 0) ? c0 : c1;
      bus.in_valid = (acc < 2);
      if (bus.in_valid && bus.in_ready) begin
        t[acc] = c;
        acc++;
      end
      if (bus.out_valid) begin
        chk("b2b_pt", bus.out_data, p[outs]);
        outs++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("b2b_outs", 128'(outs), 128'(2));
    chk("b2b_gap", 128'(t[1] - t[0]), 128'(12));
  endtask

  task automatic wait_round(input int r, input string tag);
    int n;
    n = 0;
    while (bus.rk_idx != 4'(r) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(bus.rk_idx), 128'(r));
  endtask

  initial begin
    logic [127:0] key;
    logic [127:0] ct;
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef AES_INV_ROUND_ABORT_EN
    abort = 1'b0;
`endif
    build_sbox();
    set_key(FIPS_KEY);
    chk("model_rk10", rk_tab[10], FIPS_RK10);
    chk("model_fips", ref_dec(FIPS_CT), FIPS_PT);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
    chk("rst_out_data", bus.out_data, 128'h0);
    reset = 1'b0;
    @(negedge clk);

    do_block(FIPS_CT, FIPS_PT, 0);
    do_block(FIPS_CT, FIPS_PT, 7);
    b2b({$urandom, $urandom, $urandom, $urandom}, FIPS_CT);

    // Reset in the middle of a block clears everything at once.
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_round(5, "mid_round5");
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'(10));
    @(negedge clk);
    reset = 1'b0;
    do_block(FIPS_CT, FIPS_PT, 0);

    for (int b = 0; b < 12; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      do_block(ct, ref_dec(ct), int'($urandom_range(0, 3)));
    end

`ifdef AES_INV_ROUND_ABORT_EN
    begin
      int ov;
      int xfers;
      set_key(FIPS_KEY);
      wait_idle("ab_idle");
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = FIPS_CT;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_round(3, "ab_round3");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_in_ready", 128'(bus.in_ready), 128'(1));
      chk("ab_busy", 128'(bus.busy), 128'(0));
      chk("ab_rk_idx", 128'(bus.rk_idx), 128'(10));
      chk("ab_out_data", bus.out_data, 128'h0);
      ov = 0;
      for (int k = 0; k < 12; k++) begin
        if (bus.out_valid) ov++;
        @(negedge clk);
      end
      chk("ab_no_out_valid", 128'(ov), 128'(0));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_idle_in_ready", 128'(bus.in_ready), 128'(1));
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = FIPS_CT;
      @(negedge clk);
      bus.in_valid = 1'b0;
      ov = 0;
      while (!bus.out_valid && ov < 20) begin
        @(negedge clk);
        ov++;
      end
      chk("ab_done_data", bus.out_data, FIPS_PT);
      abort = 1'b1;
      bus.out_ready = 1'b1;
      xfers = 0;
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid && bus.out_ready) xfers++;
        @(negedge clk);
        abort = 1'b0;
      end
      chk("ab_xfers", 128'(xfers), 128'(1));
      chk("ab_done_in_ready", 128'(bus.in_ready), 128'(1));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
